// File: rtl/mem_ctrl_if.sv
// ============================================================================
// Module   : mem_ctrl_if
// Purpose  : Byte-wide request/completion bus between the MEM stage and the
//            memory controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_ctrl_if;
    logic        req;
    logic        rw;      // 1 = write
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        valid;   // one-cycle completion pulse

    modport master (output req, rw, addr, wdata, input rdata, valid);
    modport slave  (input req, rw, addr, wdata, output rdata, valid);
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage; serialises loads/stores into byte accesses
//            on the memory controller and stalls the front of the pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    input  wire logic        load_enable_i,
    input  wire logic        store_enable_i,
    input  wire logic [31:0] load_store_addr_i,
    input  wire logic [31:0] store_data_i,
    input  wire logic [2:0]  funct3_i,
    input  wire logic [31:0] rd_data_i,
    input  wire logic [4:0]  rd_addr_i,
    input  wire logic        rd_write_enable_i,
    mem_ctrl_if.master       mctrl,
    output logic      [31:0] rd_data_o,
    output logic      [4:0]  rd_addr_o,
    output logic             rd_write_enable_o,
    output logic             stall_req_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] buf_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_addr_q;
    logic        rd_we_q;
    logic        rw_q;

    logic        start;
    logic [1:0]  cnt_last;
    logic [31:0] load_val;
    logic [31:0] wdata_shift;

    assign start = (state_q == S_IDLE) && (load_enable_i || store_enable_i);

    always_comb begin
        cnt_last = 2'd3;
        case (funct3_q[1:0])
            2'b00:   cnt_last = 2'd0;
            2'b01:   cnt_last = 2'd1;
            default: cnt_last = 2'd3;
        endcase
    end

    always_comb begin
        load_val = buf_q;
        case (funct3_q)
            3'b000:  load_val = {{24{buf_q[7]}},  buf_q[7:0]};
            3'b001:  load_val = {{16{buf_q[15]}}, buf_q[15:0]};
            3'b100:  load_val = {24'h0, buf_q[7:0]};
            3'b101:  load_val = {16'h0, buf_q[15:0]};
            default: load_val = buf_q;
        endcase
    end

    // Address and write byte derive only from latched state, so they stay
    // stable while the controller has not yet answered.
    assign wdata_shift = wdata_q >> {cnt_q, 3'b000};
    assign mctrl.addr  = addr_q + {30'h0, cnt_q};
    assign mctrl.wdata = wdata_shift[7:0];
    assign mctrl.rw    = rw_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCESS;
                    cnt_d   = 2'd0;
                end
            end
            S_ACCESS: begin
                if (mctrl.valid) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == cnt_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mctrl.req         = 1'b0;
        stall_req_o       = 1'b0;
        rd_data_o         = rd_data_i;
        rd_addr_o         = rd_addr_i;
        rd_write_enable_o = rd_write_enable_i;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall_req_o       = 1'b1;
                    rd_write_enable_o = 1'b0;
                end
            end
            S_ACCESS: begin
                mctrl.req         = 1'b1;
                stall_req_o       = 1'b1;
                rd_data_o         = load_val;
                rd_addr_o         = rd_addr_q;
                rd_write_enable_o = 1'b0;
            end
            S_DONE: begin
                rd_data_o         = rw_q ? 32'h0 : load_val;
                rd_addr_o         = rd_addr_q;
                rd_write_enable_o = rd_we_q && !rw_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            buf_q     <= 32'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            funct3_q  <= 3'b000;
            rd_addr_q <= 5'd0;
            rd_we_q   <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                buf_q     <= 32'h0;
                addr_q    <= load_store_addr_i;
                wdata_q   <= store_data_i;
                funct3_q  <= funct3_i;
                rd_addr_q <= rd_addr_i;
                rd_we_q   <= rd_write_enable_i;
                // A simultaneous load and store request is treated as a load.
                rw_q      <= store_enable_i && !load_enable_i;
            end else if (state_q == S_ACCESS && mctrl.valid && !rw_q) begin
                buf_q[{cnt_q, 3'b000} +: 8] <= mctrl.rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: pass-through vectors plus
//            directed load/store/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        le, se;
    logic [31:0] addr_i, sdata_i, rdi;
    logic [2:0]  f3;
    logic [4:0]  rai;
    logic        rwei;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o, stall_o;

    int checks = 0;
    int errors = 0;

    mem_ctrl_if mif ();

    mem_stage dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .load_enable_i     (le),
        .store_enable_i    (se),
        .load_store_addr_i (addr_i),
        .store_data_i      (sdata_i),
        .funct3_i          (f3),
        .rd_data_i         (rdi),
        .rd_addr_i         (rai),
        .rd_write_enable_i (rwei),
        .mctrl             (mif),
        .rd_data_o         (rd_data_o),
        .rd_addr_o         (rd_addr_o),
        .rd_write_enable_o (rd_we_o),
        .stall_req_o       (stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Holds the enables through the whole access and DONE, as the EX/MEM
    // latch would, then releases them and confirms no second access starts.
    task automatic run_access(input string nm, input bit st, input logic [2:0] f3v,
                              input logic [31:0] base, input logic [31:0] wd,
                              input logic [31:0] rbytes, input int dly,
                              input logic [31:0] exp_rd);
        int n;
        int stalls;
        logic [31:0] ea;
        logic [31:0] ew;
        n = (f3v[1:0] == 2'b00) ? 1 : (f3v[1:0] == 2'b01) ? 2 : 4;
        stalls = 0;
        @(negedge clk);
        le = !st; se = st; addr_i = base; sdata_i = wd; f3 = f3v;
        rdi = 32'hDEADBEEF; rai = 5'd9; rwei = 1'b1; mif.valid = 1'b0;
        #1;
        chk({nm, " detect stall"}, {31'h0, stall_o}, 32'h1);
        chk({nm, " detect we"},    {31'h0, rd_we_o}, 32'h0);
        chk({nm, " detect req"},   {31'h0, mif.req}, 32'h0);
        stalls += int'(stall_o);
        for (int k = 0; k < n; k++) begin
            ea = base + k;
            ew = wd >> (8 * k);
            for (int d = 0; d <= dly; d++) begin
                @(negedge clk);
                mif.valid = (d == dly);
                mif.rdata = rbytes[8*k +: 8];
                #1;
                chk({nm, " req"},  {31'h0, mif.req}, 32'h1);
                chk({nm, " addr"}, mif.addr, ea);
                chk({nm, " rw"},   {31'h0, mif.rw}, {31'h0, st});
                if (st) chk({nm, " wdata"}, {24'h0, mif.wdata}, {24'h0, ew[7:0]});
                chk({nm, " we in access"}, {31'h0, rd_we_o}, 32'h0);
                stalls += int'(stall_o);
            end
        end
        @(negedge clk);
        mif.valid = 1'b0;
        #1;
        chk({nm, " done stall"},   {31'h0, stall_o}, 32'h0);
        chk({nm, " done req"},     {31'h0, mif.req}, 32'h0);
        chk({nm, " done rd_addr"}, {27'h0, rd_addr_o}, 32'd9);
        chk({nm, " done we"},      {31'h0, rd_we_o}, st ? 32'h0 : 32'h1);
        if (!st) chk({nm, " done data"}, rd_data_o, exp_rd);
        chk({nm, " stall cycles"}, stalls, 1 + n * (dly + 1));
        @(negedge clk);
        le = 1'b0; se = 1'b0; rwei = 1'b0; rdi = 32'h0; rai = 5'd0;
        #1;
        chk({nm, " idle after"}, {31'h0, stall_o}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] rd;
        logic [4:0]  ra;
        logic        we;
        logic        v;
        logic [31:0] exp_rd;
        logic [4:0]  exp_ra;
        logic        exp_we;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{32'h0000_1234, 5'd5,  1'b1, 1'b0, 32'h0000_1234, 5'd5,  1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0};
        vecs[2] = '{32'hA5A5_5A5A, 5'd17, 1'b1, 1'b1, 32'hA5A5_5A5A, 5'd17, 1'b1};
        vecs[3] = '{32'h0000_0000, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 5'd0,  1'b0};

        rst = 1'b1; le = 1'b0; se = 1'b0; addr_i = 32'h0; sdata_i = 32'h0;
        f3 = 3'b000; rdi = 32'h0; rai = 5'd0; rwei = 1'b0;
        mif.valid = 1'b0; mif.rdata = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("reset req",   {31'h0, mif.req}, 32'h0);
        chk("reset stall", {31'h0, stall_o}, 32'h0);
        chk("reset we",    {31'h0, rd_we_o}, 32'h0);
        chk("reset data",  rd_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Pass-through; valid pulses in IDLE must be ignored.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdi = vecs[i].rd; rai = vecs[i].ra; rwei = vecs[i].we; mif.valid = vecs[i].v;
            #1;
            chk("pass data",  rd_data_o, vecs[i].exp_rd);
            chk("pass addr",  {27'h0, rd_addr_o}, {27'h0, vecs[i].exp_ra});
            chk("pass we",    {31'h0, rd_we_o}, {31'h0, vecs[i].exp_we});
            chk("pass stall", {31'h0, stall_o}, 32'h0);
            chk("pass req",   {31'h0, mif.req}, 32'h0);
        end
        @(negedge clk);
        mif.valid = 1'b0;

        run_access("LW",    1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 32'h1234_5678);
        run_access("LB",    1'b0, 3'b000, 32'h0000_0200, 32'h0, 32'h0000_0080, 0, 32'hFFFF_FF80);
        run_access("LBU",   1'b0, 3'b100, 32'h0000_0200, 32'h0, 32'h0000_0080, 0, 32'h0000_0080);
        run_access("LH",    1'b0, 3'b001, 32'h0000_0201, 32'h0, 32'h0000_F001, 0, 32'hFFFF_F001);
        run_access("LHU",   1'b0, 3'b101, 32'h0000_0201, 32'h0, 32'h0000_F001, 1, 32'h0000_F001);
        run_access("L110",  1'b0, 3'b110, 32'h0000_0FFE, 32'h0, 32'h89AB_CDEF, 0, 32'h89AB_CDEF);
        run_access("SH",    1'b1, 3'b001, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'h0, 0, 32'h0);
        run_access("SWdly", 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344, 32'h0, 3, 32'h0);
        run_access("SB",    1'b1, 3'b000, 32'h0000_0005, 32'h0000_00E7, 32'h0, 0, 32'h0);

        // Reset during the third byte of a word load.
        @(negedge clk);
        le = 1'b1; addr_i = 32'h0000_0400; f3 = 3'b010; rai = 5'd3; rwei = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mif.valid = 1'b1; mif.rdata = 8'h11;
        end
        @(negedge clk);
        mif.valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst byte2 req",  {31'h0, mif.req}, 32'h1);
        chk("rst byte2 addr", mif.addr, 32'h0000_0402);
        @(negedge clk);
        rst = 1'b0; le = 1'b0; rwei = 1'b0; rai = 5'd0;
        #1;
        chk("post rst req",   {31'h0, mif.req}, 32'h0);
        chk("post rst stall", {31'h0, stall_o}, 32'h0);
        chk("post rst we",    {31'h0, rd_we_o}, 32'h0);
        @(negedge clk);
        mif.valid = 1'b1; mif.rdata = 8'hAA;
        #1;
        chk("stray valid req",   {31'h0, mif.req}, 32'h0);
        chk("stray valid stall", {31'h0, stall_o}, 32'h0);
        @(negedge clk);
        mif.valid = 1'b0;
        #1;
        chk("after stray stall", {31'h0, stall_o}, 32'h0);

        run_access("LBpost", 1'b0, 3'b000, 32'h0000_0010, 32'h0, 32'h0000_007F, 0, 32'h0000_007F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide: clk_in  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: rst_in  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide: load_enable_i  input  1  EX/MEM-latched load request.
REQ-004 SHALL provide: store_enable_i  input  1  EX/MEM-latched store request.
REQ-005 SHALL provide: load_store_addr_i  input  32  byte address from EX.
REQ-006 SHALL provide: store_data_i  input  32  store data (rs2).
REQ-007 SHALL provide: funct3_i  input  3  access size/sign.
REQ-008 SHALL provide: rd_data_i  input  32 / rd_addr_i  input  5 / rd_write_enable_i  input  1  EX result for pass-through.
REQ-009 SHALL provide: mctrl_req_o  output  1 / mctrl_rw_o  output  1 (1=write) / mctrl_addr_o  output  32 / mctrl_wdata_o  output  8  byte request to memory controller.
REQ-010 SHALL provide: mctrl_rdata_i  input  8 / mctrl_valid_i  input  1  byte completion pulse with read data.
REQ-011 SHALL provide: rd_data_o  output  32 / rd_addr_o  output  5 / rd_write_enable_o  output  1  to MEM/WB latch and ID forwarding.
REQ-012 SHALL provide: stall_req_o  output  1  holds IF/ID/EX and EX/MEM latch.

Function
REQ-013 States SHALL be IDLE, ACCESS, DONE; encoding free.
REQ-014 IDLE, neither enable set: outputs rd_* SHALL equal rd_*_i combinationally, stall_req_o=0, mctrl_req_o=0; zero added latency.
REQ-015 IDLE, load_enable_i or store_enable_i set: stall_req_o=1 combinationally that cycle, rd_write_enable_o=0; request latched (addr, data, funct3, rd_addr, rd_write_enable, rw); next state ACCESS, byte counter cnt=0.
REQ-016 Byte count n SHALL be 1 for funct3[1:0]=00, 2 for 01, 4 for 10 and 11.
REQ-017 ACCESS: mctrl_req_o=1, mctrl_addr_o=base+cnt (mod 2^32), mctrl_rw_o=latched rw, mctrl_wdata_o=store byte cnt (little-endian, bits 8*cnt+7:8*cnt); stall_req_o=1, rd_write_enable_o=0.
REQ-018 ACCESS, mctrl_valid_i=1: load SHALL capture mctrl_rdata_i into byte cnt of buffer; cnt increments; if cnt==n-1 next state DONE, else stay ACCESS with new address next cycle.
REQ-019 ACCESS, mctrl_valid_i=0: all mctrl_* outputs SHALL hold stable.
REQ-020 mctrl_valid_i outside ACCESS SHALL be ignored.
REQ-021 DONE: stall_req_o=0, mctrl_req_o=0, rd_addr_o=latched rd_addr, rd_write_enable_o=latched enable (load) or 0 (store); next state IDLE unconditionally.
REQ-022 Load result: funct3 000 sign-extend byte, 001 sign-extend half, 010/011 word, 100 zero-extend byte, 101 zero-extend half; 110/111 treated as word.
REQ-023 Misaligned and page-crossing addresses SHALL be served byte-serially with no exception.
REQ-024 Enables seen in DONE SHALL NOT start a new access; the EX/MEM latch advances at end of DONE.
REQ-025 Stall cycles for an access SHALL be 1 (IDLE detect) plus all ACCESS cycles; result visible exactly one cycle (DONE).

Reset
REQ-026 rst_in=1 at a rising edge SHALL force state IDLE, cnt=0, buffer=0, latched request cleared, from the next cycle, including mid-ACCESS (pending byte abandoned).
REQ-027 During and after reset in IDLE, mctrl_req_o=0, stall_req_o=0, rd_write_enable_o=0 until a new enable; rd_data_o=0 when rd_*_i are 0.

Verification
REQ-028 Pass-through: rd_data_i=0x1234, rd_addr_i=5, we=1, no enables -> same-cycle rd_data_o=0x1234, rd_addr_o=5, stall_req_o=0.
REQ-029 LW addr 0x100, controller valid 1 cycle after each req, bytes 0x78,0x56,0x34,0x12 -> addresses 0x100..0x103 in order, DONE rd_data_o=0x12345678, stall high 5 cycles.
REQ-030 LB 0x200 byte 0x80 -> rd_data_o=0xFFFFFF80; LBU same -> 0x00000080; LH 0x201 bytes 0x01,0xF0 -> 0xFFFFF001.
REQ-031 SH addr 0xFFFFFFFF data 0xAABBCCDD -> writes 0xDD to 0xFFFFFFFF, 0xCC to 0x00000000, rw=1, rd_write_enable_o=0 in DONE.
REQ-032 Controller valid delayed 3 cycles per byte on SW -> mctrl_addr_o/wdata stable while waiting, stall held throughout.
REQ-033 rst_in pulsed during byte 2 of LW -> next cycle IDLE, mctrl_req_o=0, stall_req_o=0; later valid pulse ignored.
